// File: rtl/descramble_pdu.sv
// BTLE receive dewhitening (x^7+x^4+1, channel seeded) with PDU framing:
// decodes the header length octet and flags the final CRC bit of each frame.
module descramble_pdu #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int HEADER_BIT_LENGTH        = 16,
    parameter int CRC_BIT_LENGTH           = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                data_in,
    input  logic                                data_in_valid,
    output logic                                data_out,
    output logic                                data_out_valid,
    output logic                                data_out_valid_last,
    output logic [7:0]                          payload_length,
    output logic                                payload_length_valid
);

    localparam logic [10:0] HDR_LAST = 11'(HEADER_BIT_LENGTH - 1);
    localparam logic [10:0] CRC_LAST = 11'(CRC_BIT_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  lfsr;
    logic [6:0]  seed;
    logic [10:0] bit_cnt;
    logic [7:0]  len_shift;
    logic [7:0]  len_new;
    logic        accept;
    logic        w;
    logic        bit_out;
    logic        cnt_clr;
    logic        last_bit;
    logic        len_done;

    // s[0]=1, s[1]=channel MSB ... s[6]=channel LSB
    assign seed = {channel_number[0], channel_number[1], channel_number[2],
                   channel_number[3], channel_number[4], channel_number[5], 1'b1};

    assign accept  = data_in_valid && !channel_number_load && (state != IDLE);
    assign w       = lfsr[6];
    assign bit_out = data_in ^ w;
    // Header bits arrive LSB first; after bit 15 the top octet is the length.
    assign len_new = {bit_out, len_shift[7:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        last_bit   = 1'b0;
        len_done   = 1'b0;
        case (state)
            HEADER: begin
                if (accept && bit_cnt == HDR_LAST) begin
                    len_done   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = (len_new != 8'd0) ? PAYLOAD : CRC;
                end
            end
            PAYLOAD: begin
                if (accept && bit_cnt == ({payload_length, 3'b000} - 11'd1)) begin
                    cnt_clr    = 1'b1;
                    state_next = CRC;
                end
            end
            CRC: begin
                if (accept && bit_cnt == CRC_LAST) begin
                    last_bit   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: ;
        endcase
        // A load always restarts framing, aborting any frame in progress.
        if (channel_number_load) begin
            state_next = HEADER;
            cnt_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr                 <= 7'd0;
            bit_cnt              <= 11'd0;
            len_shift            <= 8'd0;
            payload_length       <= 8'd0;
            data_out             <= 1'b0;
            data_out_valid       <= 1'b0;
            data_out_valid_last  <= 1'b0;
            payload_length_valid <= 1'b0;
        end else begin
            if (channel_number_load)
                lfsr <= seed;
            else if (last_bit)
                lfsr <= 7'd0;
            else if (accept)
                lfsr <= {lfsr[5], lfsr[4], lfsr[3] ^ w, lfsr[2], lfsr[1], lfsr[0], w};

            if (cnt_clr)     bit_cnt <= 11'd0;
            else if (accept) bit_cnt <= bit_cnt + 11'd1;

            if (accept && state == HEADER) len_shift <= len_new;
            if (len_done) payload_length <= len_new;
            if (accept) data_out <= bit_out;

            data_out_valid       <= accept;
            data_out_valid_last  <= last_bit;
            payload_length_valid <= len_done;
        end
    end

endmodule
